// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router packet transmitter
package router_pkg;
  localparam int MAX_LEN = 63;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam logic [7:0] PAR_CORRUPT_MASK = 8'h01;
  typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, ERRW} state_e;
endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: 64x8 payload buffer, synchronous write, asynchronous read
module router_tx_buf
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             we_i,
  input  logic [LEN_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [LEN_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);
  logic [7:0] mem_q [MAX_LEN+1];
  // payload bytes written as the host delivers them
  always_ff @(posedge clock) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a host payload and drives the router input protocol
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int ERR_WAIT = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest,
  input  logic [LEN_W-1:0]  len,
  input  logic              corrupt,
  output logic              ready,
  output logic              req_err,
  input  logic [7:0]        pay_data,
  input  logic              pay_valid,
  output logic              pay_ready,
  output logic              pkt_valid,
  output logic [7:0]        tx_data,
  input  logic              busy,
  input  logic              error,
  output logic              done,
  output logic              pkt_err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic corrupt_q, corrupt_d, flag_q, flag_d;
  logic [7:0] par_q, par_d, tx_data_q, tx_data_d, rdata;
  logic [3:0] cnt_q, cnt_d;
  logic pkt_valid_q, pkt_valid_d, req_err_q, req_err_d, done_q, done_d, pkt_err_q, pkt_err_d;
  logic we;
  router_tx_buf u_buf (
    .clock   (clock),
    .we_i    (we),
    .waddr_i (idx_q),
    .wdata_i (pay_data),
    .raddr_i (idx_d),
    .rdata_o (rdata)
  );
  // next state, counters and parity; registered outputs are decoded from the next state
  always_comb begin
    state_d = state_q;
    dest_d = dest_q;
    len_d = len_q;
    corrupt_d = corrupt_q;
    par_d = par_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    flag_d = flag_q;
    we = 1'b0;
    req_err_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (len == '0 || dest == 2'd3) req_err_d = 1'b1;
        else begin
          dest_d = dest;
          len_d = len;
          corrupt_d = corrupt;
          par_d = {len, dest};
          idx_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: if (pay_valid) begin
        we = 1'b1;
        par_d = par_q ^ pay_data;
        idx_d = idx_q + 6'd1;
        if (idx_q == len_q - 6'd1) begin
          idx_d = '0;
          state_d = HDR;
        end
      end
      HDR: if (!busy) state_d = PAY;
      PAY: if (!busy) begin
        if (idx_q == len_q - 6'd1) state_d = PAR;
        else idx_d = idx_q + 6'd1;
      end
      PAR: if (!busy) begin
        cnt_d = 4'(ERR_WAIT);
        flag_d = 1'b0;
        state_d = ERRW;
      end
      ERRW: begin
        flag_d = flag_q | error;
        if (cnt_q == '0) begin
          done_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    pkt_err_d = done_d ? flag_d : pkt_err_q;
    pkt_valid_d = state_d == HDR || state_d == PAY;
    tx_data_d = state_d == HDR ? {len_q, dest_q} :
                state_d == PAY ? rdata :
                state_d == PAR ? par_q ^ (corrupt_q ? PAR_CORRUPT_MASK : 8'h00) : 8'h00;
  end
  // state and registered outputs; reset returns to IDLE at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      dest_q <= '0;
      len_q <= '0;
      corrupt_q <= 1'b0;
      par_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      flag_q <= 1'b0;
      tx_data_q <= '0;
      pkt_valid_q <= 1'b0;
      req_err_q <= 1'b0;
      done_q <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q <= dest_d;
      len_q <= len_d;
      corrupt_q <= corrupt_d;
      par_q <= par_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      flag_q <= flag_d;
      tx_data_q <= tx_data_d;
      pkt_valid_q <= pkt_valid_d;
      req_err_q <= req_err_d;
      done_q <= done_d;
      pkt_err_q <= pkt_err_d;
    end
  end
  assign ready = state_q == IDLE;
  assign pay_ready = state_q == LOAD;
  assign pkt_valid = pkt_valid_q;
  assign tx_data = tx_data_q;
  assign req_err = req_err_q;
  assign done = done_q;
  assign pkt_err = pkt_err_q;
endmodule
